packet_arbiter: RTL and testbench
=================================

// Module: packet_arbiter
//
// PURPOSE
// Shares one byte-wide UART TX stream between NumReq framed packet sources (e.g. the
// image framer and a status/telemetry framer). Grants one source at a time, round-robin,
// and holds the grant for a whole packet, released when the TailByte0,TailByte1 footer passes.
// A byte-count watchdog forces release if a source never sends its footer.
// Sits between the framers and the UART transmitter.
//
// PARAMETERS
// NumReq         2      number of requesting byte streams (>=2)
// DataWidth      8      byte width of every stream
// TailByte0      8'h0D  first footer byte
// TailByte1      8'h0A  second footer byte; the fire of this byte right after TailByte0 ends the packet
// MaxPacketBytes 4096   watchdog limit; the grant is released after this many bytes without a footer
//
// PORTS
// clk_i      in   1                   clock, all state on rising edge
// rst_ni     in   1                   asynchronous, active-low reset
// valid_i    in   NumReq              per-requester byte valid
// ready_o    out  NumReq              per-requester ready; at most one bit high
// data_i     in   NumReq*DataWidth    requester r byte at [r*DataWidth +: DataWidth]
// valid_o    out  1                   byte valid toward UART TX
// ready_i    in   1                   UART TX ready
// data_o     out  DataWidth           selected byte
// grant_o    out  NumReq              one-hot current owner, 0 when Idle
// busy_o     out  1                   1 in Busy state
// overrun_o  out  1                   1-cycle pulse when the watchdog forces release
//
// BEHAVIOUR
// - Reset (async assert, sync deassert assumed externally): state=Idle, grant_q=0, last_q=NumReq-1,
//   seen0_q=0, count_q=0. ready_o=0, valid_o=0, data_o=0, grant_o=0, busy_o=0, overrun_o=0.
//   Reset mid-packet drops the grant immediately. The partial packet is not resumed.
// - fire = valid_o && ready_i. Data path is combinational: zero latency once granted.
// - Idle: ready_o=0, valid_o=0, data_o=0. If any valid_i is high, the winner is the first asserted index
//   searching last_q+1, last_q+2, ... modulo NumReq. Register grant_q=winner and go to Busy.
//   Arbitration costs exactly 1 cycle; no byte moves in the cycle a decision is made.
// - Busy: valid_o=valid_i[g], data_o=data_i[g], ready_o[g]=ready_i, and all other ready_o bits are 0.
//   Valid_i dropping low while Busy keeps the grant; there is no idle timeout.
// - Footer detect, on each fire in Busy:
//   - end = seen0_q && data_o==TailByte1.
//   - seen0_q <= (data_o==TailByte0), so 0D,0D,0A still ends the packet.
//   - Bytes that do not fire leave seen0_q unchanged.
// - Watchdog: count_q increments on each fire in Busy, with width $clog2(MaxPacketBytes+1).
//   wd = fire && count_q==MaxPacketBytes-1 && !end.
// - On end or wd: the footer/limit byte is transferred, then next cycle state=Idle, last_q=g,
//   grant_q=0, seen0_q=0, count_q=0. overrun_o=1 on the cycle after a wd fire, else 0.
//   If end and wd coincide, the event is treated as end and there is no overrun.
// - A requester with valid_i high in the release cycle may win again only if no other index
//   is asserted. This follows from the round-robin order starting at last_q+1.
// - Invariants:
//   - $onehot0(ready_o).
//   - ready_o != 0 implies busy_o.
//   - grant_o == (busy_o ? 1<<g : 0).
//
// TESTING
// - Reset: hold rst_ni=0 with both valid_i=1 -> all outputs 0. After deassert: Idle 1 cycle,
//   then grant_o=2'b01 (last_q=1, so index 0 has priority).
// - Single packet: req0 sends 41,42,0D,0A with ready_i=1 -> data_o shows the 4 bytes on 4
//   consecutive cycles, then busy_o=0 the next cycle.
// - Round robin: req0 and req1 both hold packets continuously -> grants alternate 01,10,01.
//   Each packet is contiguous and there is exactly 1 Idle cycle between packets.
// - Footer edge cases: bytes 0D,0D,0A end the packet. Bytes 0D,55,0A do not end it.
//   A 0D followed by ready_i=0 for 5 cycles, then 0A, ends the packet.
// - Watchdog: MaxPacketBytes=8, req1 streams 00 bytes -> release after the 8th fire and
//   overrun_o pulses once. A footer on the 8th byte (bytes 7-8 = 0D,0A) releases with overrun_o=0.
// - Backpressure/mid-reset: ready_i toggling randomly -> no byte is lost or duplicated.
//   rst_ni asserted mid-packet -> ready_o=0 the same cycle, and the next grant follows the reset round-robin order.

Source files
------------

// File: rtl/packet_arbiter_if.sv
// Purpose: byte-stream bundle between NumReq framers, the arbiter and the UART TX.
// Latency: none, wires only.
// Backpressure: valid/ready per requester toward the arbiter, one valid/ready pair toward the UART.
interface packet_arbiter_if #(
  parameter int NumReq    = 2,
  parameter int DataWidth = 8
);
  logic [NumReq-1:0]           valid_i;
  logic [NumReq-1:0]           ready_o;
  logic [NumReq*DataWidth-1:0] data_i;
  logic                        valid_o;
  logic                        ready_i;
  logic [DataWidth-1:0]        data_o;
  logic [NumReq-1:0]           grant_o;
  logic                        busy_o;
  logic                        overrun_o;

  // Sources and sink side: drives requests and UART ready, observes everything else.
  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, grant_o, busy_o, overrun_o
  );

  // Arbiter side.
  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, grant_o, busy_o, overrun_o
  );
endinterface

// File: rtl/packet_arbiter.sv
// Purpose: round-robin arbiter that hands one UART TX byte stream to one framer for a whole packet.
// Latency: 1 idle cycle to arbitrate, then zero-latency combinational byte path while granted.
// Backpressure: UART ready_i is passed straight to the granted requester; all others see ready=0.
module packet_arbiter #(
  parameter int                   NumReq         = 2,
  parameter int                   DataWidth      = 8,
  parameter logic [DataWidth-1:0] TailByte0      = 8'h0D,
  parameter logic [DataWidth-1:0] TailByte1      = 8'h0A,
  parameter int                   MaxPacketBytes = 4096
) (
  input logic               clk_i,
  input logic               rst_ni,
  packet_arbiter_if.slave   bus
);
  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(MaxPacketBytes + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q;
  logic [IdxW-1:0] grant_q;
  logic [IdxW-1:0] last_q;
  logic            seen0_q;
  logic [CntW-1:0] count_q;
  logic            overrun_q;

  logic [IdxW-1:0]      win;
  logic [IdxW-1:0]      cand;
  logic                 found;
  logic [DataWidth-1:0] lanes [NumReq];
  logic                 valid;
  logic [DataWidth-1:0] data;
  logic [NumReq-1:0]    ready;
  logic [NumReq-1:0]    grant;
  logic                 fire;
  logic                 pkt_end;
  logic                 wd;

  // Round-robin pick: first asserted request after the previous owner.
  always_comb begin
    win   = last_q;
    cand  = last_q;
    found = 1'b0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = IdxW'((int'(last_q) + k) % NumReq);
      if (!found && bus.valid_i[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Steer the granted lane to the UART and UART ready back to the owner only.
  always_comb begin
    for (int r = 0; r < NumReq; r++) begin
      lanes[r] = bus.data_i[r*DataWidth +: DataWidth];
    end
    valid = 1'b0;
    data  = '0;
    ready = '0;
    grant = '0;
    if (state_q == BUSY) begin
      valid          = bus.valid_i[grant_q];
      data           = lanes[grant_q];
      ready[grant_q] = bus.ready_i;
      grant[grant_q] = 1'b1;
    end
  end

  // Footer 0D,0A ends the packet; the watchdog only fires when the limit byte is not itself a footer.
  assign fire    = valid && bus.ready_i;
  assign pkt_end = fire && seen0_q && (data == TailByte1);
  assign wd      = fire && (count_q == CntW'(MaxPacketBytes - 1)) && !pkt_end;

  // Grant FSM: arbitrate in IDLE, hold the owner through BUSY until footer or watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IdxW'(NumReq - 1);
      seen0_q   <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus.valid_i) begin
            grant_q <= win;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (pkt_end || wd) begin
            state_q   <= IDLE;
            last_q    <= grant_q;
            grant_q   <= '0;
            seen0_q   <= 1'b0;
            count_q   <= '0;
            overrun_q <= wd;
          end else if (fire) begin
            seen0_q <= (data == TailByte0);
            count_q <= count_q + CntW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.valid_o   = valid;
  assign bus.data_o    = data;
  assign bus.ready_o   = ready;
  assign bus.grant_o   = grant;
  assign bus.busy_o    = (state_q == BUSY);
  assign bus.overrun_o = overrun_q;
endmodule

// File: tb/tb_packet_arbiter.sv
// Purpose: directed self-checking bench for packet_arbiter (2 requesters, 8-byte watchdog).
// Latency: inputs applied 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: exercised with held-low and random UART ready.
module tb_packet_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  packet_arbiter_if #(.NumReq(2), .DataWidth(8)) bus ();

  packet_arbiter #(
    .NumReq(2), .DataWidth(8), .TailByte0(8'h0D), .TailByte1(8'h0A), .MaxPacketBytes(8)
  ) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] vin;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic [14:0] exp;   // {valid_o, data_o, ready_o, grant_o, busy_o, overrun_o}
  } vec_t;

  function automatic logic [14:0] outs();
    return {bus.valid_o, bus.data_o, bus.ready_o, bus.grant_o, bus.busy_o, bus.overrun_o};
  endfunction

  function automatic vec_t idle_row(logic r, logic [1:0] v);
    vec_t x;
    x = '{rst: r, vin: v, d0: 8'h41, d1: 8'h42, rdy: 1'b1, exp: 15'h0};
    return x;
  endfunction

  function automatic vec_t b0(logic [1:0] v, logic [7:0] d, logic rdy);
    vec_t x;
    x = '{rst: 1'b1, vin: v, d0: d, d1: 8'hEE, rdy: rdy,
          exp: {v[0], d, 1'b0, rdy, 2'b01, 1'b1, 1'b0}};
    return x;
  endfunction

  function automatic vec_t b1(logic [1:0] v, logic [7:0] d, logic rdy);
    vec_t x;
    x = '{rst: 1'b1, vin: v, d0: 8'hEE, d1: d, rdy: rdy,
          exp: {v[1], d, rdy, 1'b0, 2'b10, 1'b1, 1'b0}};
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  task automatic drive(logic r, logic [1:0] v, logic [7:0] d0, logic [7:0] d1, logic rdy);
    @(posedge clk);
    #1;
    rst_n       = r;
    bus.valid_i = v;
    bus.data_i  = {d1, d0};
    bus.ready_i = rdy;
    @(negedge clk);
  endtask

  vec_t       vecs[$];
  logic [7:0] pk0[5];
  logic [7:0] pk1[4];
  logic [7:0] exp_q[$];
  logic [7:0] rx[$];
  int         p0, p1, bad_inv;
  logic       f0, f1;

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.valid_i = 2'b11;
    bus.data_i  = '0;
    bus.ready_i = 1'b1;

    // Reset, single packet, footer corner cases, round robin.
    vecs.push_back(idle_row(1'b0, 2'b11));
    vecs.push_back(idle_row(1'b1, 2'b11));
    vecs.push_back(b0(2'b01, 8'h41, 1'b1));
    vecs.push_back(b0(2'b01, 8'h42, 1'b1));
    vecs.push_back(b0(2'b01, 8'h0D, 1'b1));
    vecs.push_back(b0(2'b01, 8'h0A, 1'b1));
    vecs.push_back(idle_row(1'b1, 2'b00));
    vecs.push_back(idle_row(1'b1, 2'b01));
    vecs.push_back(b0(2'b01, 8'h0D, 1'b1));
    vecs.push_back(b0(2'b01, 8'h0D, 1'b1));
    vecs.push_back(b0(2'b01, 8'h0A, 1'b1));
    vecs.push_back(idle_row(1'b1, 2'b01));
    vecs.push_back(b0(2'b01, 8'h0D, 1'b1));
    vecs.push_back(b0(2'b01, 8'h55, 1'b1));
    vecs.push_back(b0(2'b01, 8'h0A, 1'b1));
    vecs.push_back(b0(2'b01, 8'h0D, 1'b1));
    for (int i = 0; i < 5; i++) vecs.push_back(b0(2'b01, 8'h0A, 1'b0));
    vecs.push_back(b0(2'b01, 8'h0A, 1'b1));
    vecs.push_back(idle_row(1'b1, 2'b11));
    vecs.push_back(b1(2'b11, 8'hB1, 1'b1));
    vecs.push_back(b1(2'b11, 8'h0D, 1'b1));
    vecs.push_back(b1(2'b11, 8'h0A, 1'b1));
    vecs.push_back(idle_row(1'b1, 2'b11));
    vecs.push_back(b0(2'b11, 8'hA1, 1'b1));
    vecs.push_back(b0(2'b11, 8'h0D, 1'b1));
    vecs.push_back(b0(2'b11, 8'h0A, 1'b1));
    vecs.push_back(idle_row(1'b1, 2'b11));
    vecs.push_back(b1(2'b11, 8'hB2, 1'b1));
    vecs.push_back(b1(2'b11, 8'h0D, 1'b1));
    vecs.push_back(b1(2'b11, 8'h0A, 1'b1));
    vecs.push_back(idle_row(1'b1, 2'b00));

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0) begin
        rst_n       = vecs[i].rst;
        bus.valid_i = vecs[i].vin;
        bus.data_i  = {vecs[i].d1, vecs[i].d0};
        bus.ready_i = vecs[i].rdy;
        @(negedge clk);
      end else begin
        drive(vecs[i].rst, vecs[i].vin, vecs[i].d0, vecs[i].d1, vecs[i].rdy);
      end
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Watchdog: req1 streams 00 bytes, released after the 8th fire with one overrun pulse.
    drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b1);
    chk("wd_arb_idle", 32'(bus.busy_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b1);
      chk($sformatf("wd_byte%0d", i), 32'({bus.busy_o, bus.grant_o, bus.ready_o}), 32'b11010);
    end
    drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b1);
    chk("wd_release", 32'(bus.busy_o), 32'd0);
    chk("wd_overrun", 32'(bus.overrun_o), 32'd1);
    // Footer landing on the 8th byte releases cleanly.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'b10, 8'h00, (i == 6) ? 8'h0D : (i == 7) ? 8'h0A : 8'h00, 1'b1);
      if (i == 0) chk("wd_pulse_once", 32'(bus.overrun_o), 32'd0);
      chk($sformatf("wdf_byte%0d", i), 32'(bus.busy_o), 32'd1);
    end
    drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
    chk("wdf_release", 32'(bus.busy_o), 32'd0);
    chk("wdf_no_overrun", 32'(bus.overrun_o), 32'd0);

    // Random UART backpressure with both sources always holding packets.
    pk0 = '{8'h10, 8'h11, 8'h12, 8'h0D, 8'h0A};
    pk1 = '{8'h20, 8'h21, 8'h0D, 8'h0A};
    for (int k = 0; k < 3; k++) begin
      foreach (pk0[j]) exp_q.push_back(pk0[j]);
      foreach (pk1[j]) exp_q.push_back(pk1[j]);
    end
    p0 = 0; p1 = 0; f0 = 1'b0; f1 = 1'b0; bad_inv = 0;
    for (int c = 0; c < 600 && rx.size() < 27; c++) begin
      @(posedge clk);
      #1;
      if (f0) p0 = (p0 + 1) % 5;
      if (f1) p1 = (p1 + 1) % 4;
      bus.valid_i = 2'b11;
      bus.data_i  = {pk1[p1], pk0[p0]};
      bus.ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      f0 = bus.ready_o[0];
      f1 = bus.ready_o[1];
      if (bus.ready_o == 2'b11 || (bus.ready_o != 2'b00 && !bus.busy_o)) bad_inv++;
      if (bus.valid_o && bus.ready_i) rx.push_back(bus.data_o);
    end
    chk("bp_count", 32'(rx.size()), 32'd27);
    chk("bp_invariants", 32'(bad_inv), 32'd0);
    for (int i = 0; i < rx.size() && i < 27; i++)
      chk($sformatf("bp_byte%0d", i), 32'(rx[i]), 32'(exp_q[i]));

    // Mid-packet reset: finish a req0 packet, grant req1, reset while req1 owns the stream.
    drive(1'b1, 2'b11, 8'h0D, 8'h20, 1'b1);
    drive(1'b1, 2'b11, 8'h0D, 8'h20, 1'b1);
    chk("mr_owner0", 32'(bus.grant_o), 32'b01);
    drive(1'b1, 2'b11, 8'h0A, 8'h20, 1'b1);
    drive(1'b1, 2'b11, 8'h10, 8'h20, 1'b1);
    drive(1'b1, 2'b11, 8'h10, 8'h20, 1'b1);
    chk("mr_owner1", 32'(bus.ready_o), 32'b10);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_ready_same_cycle", 32'({bus.ready_o, bus.valid_o, bus.busy_o, bus.grant_o}), 32'd0);
    @(negedge clk);
    drive(1'b0, 2'b11, 8'h10, 8'h20, 1'b1);
    drive(1'b1, 2'b11, 8'h10, 8'h20, 1'b1);
    chk("mr_idle_after_reset", 32'(bus.busy_o), 32'd0);
    drive(1'b1, 2'b11, 8'h10, 8'h20, 1'b1);
    chk("mr_rr_order", 32'(bus.grant_o), 32'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
